// File: rtl/rx_top.sv
// Receive-side UART: 16x oversampled deframer (7/8 data, none/even/odd parity,
// 1/2 stop) feeding a show-ahead FIFO of {frm_err, par_err, data} entries.
module rx_top #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DBITS    = 8,
  parameter int unsigned DEPTH    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx,
  input  logic             i_d_num,
  input  logic             i_s_num,
  input  logic [1:0]       i_par,
  input  logic [1:0]       i_bd_rate,
  input  logic             i_rd,
  output logic [DBITS-1:0] o_rd_data,
  output logic             o_par_err,
  output logic             o_frm_err,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int unsigned DIV0 = (CLK_FREQ + 1200 * 16 - 1) / (1200 * 16);
  localparam int unsigned DIV1 = (CLK_FREQ + 2400 * 16 - 1) / (2400 * 16);
  localparam int unsigned DIV2 = (CLK_FREQ + 4800 * 16 - 1) / (4800 * 16);
  localparam int unsigned DIV3 = (CLK_FREQ + 9600 * 16 - 1) / (9600 * 16);
  localparam int unsigned TW   = $clog2(DIV0 + 1);
  localparam int unsigned BW   = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned EW   = DBITS + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Error is 1 when the received parity bit disagrees with the selected sense.
  function automatic logic parity_err(input logic [DBITS-1:0] data,
                                      input logic pbit, input logic odd);
    parity_err = (^data) ^ pbit ^ odd;
  endfunction

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic             fall_s, tick_s, start_s, mid_s, par_en_s;
  logic [1:0]       bd_sel_s;
  logic [TW-1:0]    div_m1_s, tick_cnt_q, tick_cnt_d;
  state_t           state_q, state_d;
  logic [3:0]       s_cnt_q, s_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d, last_bit_s;
  logic             stop_cnt_q, stop_cnt_d;
  logic [DBITS-1:0] data_q, data_d;
  logic             par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic             busy_q, busy_d;
  logic             d_num_q, d_num_d, s_num_q, s_num_d;
  logic [1:0]       par_q, par_d, bd_q, bd_d;
  logic             wr_q, wr_d;
  logic [EW-1:0]    wr_data_q, wr_data_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_rd_s, do_wr_s;
  logic [EW-1:0]    head_q, head_d;
  logic             empty_q, full_q, overrun_q, overrun_d;

  // Two-stage synchronizer plus edge register for start detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= i_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign fall_s   = rx_prev_q & ~rx_s2_q;
  assign bd_sel_s = (state_q == IDLE) ? i_bd_rate : bd_q;
  assign par_en_s = (par_q == 2'b01) || (par_q == 2'b10);
  assign last_bit_s = d_num_q ? BW'(DBITS - 1) : BW'(DBITS - 2);

  // Baud divisor selection: live rate while idle, latched rate during a frame.
  always_comb begin
    case (bd_sel_s)
      2'b00:   div_m1_s = TW'(DIV0 - 1);
      2'b01:   div_m1_s = TW'(DIV1 - 1);
      2'b10:   div_m1_s = TW'(DIV2 - 1);
      2'b11:   div_m1_s = TW'(DIV3 - 1);
      default: div_m1_s = TW'(DIV3 - 1);
    endcase
  end

  // Oversample tick counter; >= guards a rate change while idle.
  assign tick_s = (tick_cnt_q >= div_m1_s);
  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (start_s || tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  assign mid_s = tick_s && (s_cnt_q == 4'd15);

  // Deframer next-state logic.
  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    busy_d     = busy_q;
    d_num_d    = d_num_q;
    s_num_d    = s_num_q;
    par_d      = par_q;
    bd_d       = bd_q;
    wr_d       = 1'b0;
    wr_data_d  = wr_data_q;
    start_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_s) begin
          state_d    = START;
          start_s    = 1'b1;
          s_cnt_d    = 4'd0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          data_d     = '0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
          d_num_d    = i_d_num;
          s_num_d    = i_s_num;
          par_d      = i_par;
          bd_d       = i_bd_rate;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s && (s_cnt_q == 4'd7)) begin
          s_cnt_d = 4'd0;
          if (!rx_s2_q) begin
            state_d = DATA;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          s_cnt_d = s_cnt_q + {3'd0, tick_s};
        end
      end
      DATA: begin
        s_cnt_d = s_cnt_q + {3'd0, tick_s};
        if (mid_s) begin
          data_d[bit_cnt_q] = rx_s2_q;
          if (bit_cnt_q == last_bit_s) begin
            bit_cnt_d = '0;
            state_d   = par_en_s ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      PARITY: begin
        s_cnt_d = s_cnt_q + {3'd0, tick_s};
        if (mid_s) begin
          par_err_d = parity_err(data_q, rx_s2_q, par_q == 2'b10);
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        s_cnt_d = s_cnt_q + {3'd0, tick_s};
        if (mid_s) begin
          frm_err_d = frm_err_q | ~rx_s2_q;
          if (stop_cnt_q == s_num_q) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            wr_d      = 1'b1;
            wr_data_d = {frm_err_q | ~rx_s2_q, par_err_q, data_q};
          end else begin
            stop_cnt_d = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Deframer state and frame configuration registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      s_cnt_q    <= 4'd0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      d_num_q    <= 1'b1;
      s_num_q    <= 1'b0;
      par_q      <= 2'b00;
      bd_q       <= 2'b00;
      wr_q       <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      s_cnt_q    <= s_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      busy_q     <= busy_d;
      d_num_q    <= d_num_d;
      s_num_q    <= s_num_d;
      par_q      <= par_d;
      bd_q       <= bd_d;
      wr_q       <= wr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // FIFO control; a pop frees the slot for a same-cycle write when full.
  assign do_rd_s = i_rd && (count_q != '0);
  assign do_wr_s = wr_q && ((count_q != CW'(DEPTH)) || do_rd_s);

  // FIFO next state and registered show-ahead head.
  always_comb begin
    overrun_d = wr_q && (count_q == CW'(DEPTH)) && !do_rd_s;
    rd_ptr_d  = rd_ptr_q + AW'(do_rd_s);
    wr_ptr_d  = wr_ptr_q + AW'(do_wr_s);
    count_d   = count_q + CW'(do_wr_s) - CW'(do_rd_s);
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_wr_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_data_q;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr_data_q;
    end
  end

  // FIFO pointers, count and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == CW'(DEPTH));
      overrun_q <= overrun_d;
    end
  end

  assign o_rd_data = head_q[DBITS-1:0];
  assign o_par_err = head_q[DBITS];
  assign o_frm_err = head_q[DBITS+1];
  assign o_empty   = empty_q;
  assign o_full    = full_q;
  assign o_overrun = overrun_q;
  assign o_busy    = busy_q;

endmodule

// File: doc/rx_top.md
# rx_top

Receive-side UART top: oversamples the serial line at 16x the selected baud rate, deframes 7/8 data bits with optional even/odd parity and 1/2 stop bits, and buffers received characters with per-character error flags in a show-ahead FIFO. It is the counterpart of the transmit top and accepts the same runtime configuration encodings, so a looped-back pair with matching settings transfers data unchanged.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- DBITS, 8, maximum data bits per character
- DEPTH, 8, FIFO entries; power of two, at least 2
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_rx  in  1  asynchronous serial input; idles high
- i_d_num  in  1  0: 7 data bits; 1: 8 data bits
- i_s_num  in  1  0: 1 stop bit; 1: 2 stop bits
- i_par  in  2  00: none; 01: even; 10: odd; 11: treated as none
- i_bd_rate  in  2  00: 1200; 01: 2400; 10: 4800; 11: 9600 baud
- i_rd  in  1  pop the FIFO head; ignored when o_empty
- o_rd_data  out  DBITS  FIFO head data, valid while !o_empty
- o_par_err  out  1  parity-error flag of the FIFO head
- o_frm_err  out  1  framing-error flag of the FIFO head
- o_empty  out  1  FIFO empty
- o_full  out  1  FIFO full
- o_overrun  out  1  one-cycle pulse when a completed character is dropped
- o_busy  out  1  high from start-bit confirmation through the final stop sample

## Operation
- i_rx passes through a 2-FF synchronizer before any use.
- Tick generator: divisor N = ceil(CLK_FREQ/(baud*16)). At 50 MHz: 2605, 1303, 652, 326. Emits a one-cycle tick every N clocks. It free-runs in IDLE and restarts from 0 on start detection.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: a synchronized high-to-low transition latches i_d_num, i_s_num, i_par and i_bd_rate for the whole frame, then enters START. Config changes mid-frame have no effect.
- START: counts ticks. On the 8th tick (mid-bit), a low line enters DATA. A high line is a glitch and returns to IDLE with no FIFO write.
- DATA: every 16th tick, samples the line and shifts it in LSB first. Runs 7 or 8 bits. For 7-bit characters, o_rd_data[7] = 0. Then goes to PARITY if parity is enabled, otherwise to STOP.
- PARITY: samples one bit. Parity error:
  - even: XOR of data bits and the parity bit = 1
  - odd: XOR of data bits and the parity bit = 0
- STOP: samples 1 or 2 stop bits, 16 ticks apart. Any low stop sample sets the framing error. After the last stop sample, go to IDLE and write {frm_err, par_err, data}.
- Return to IDLE happens at mid-stop-bit, so a start edge that arrives in the second half of the stop bit is detected.
- FIFO write when full:
  - if i_rd is asserted in the same cycle, both the pop and the write occur;
  - otherwise the character is dropped and o_overrun pulses for one cycle.
- Read and write in the same cycle when not empty: both occur, count unchanged.
- Pointers wrap modulo DEPTH. Full/empty use a DEPTH+1 count, or extra pointer MSBs.

## Timing
- All outputs are registered. Reset values:
  - o_rd_data = 0, o_par_err = 0, o_frm_err = 0
  - o_empty = 1, o_full = 0, o_overrun = 0, o_busy = 0
  - FSM in IDLE, tick counter 0
- Reset mid-frame aborts the frame and empties the FIFO. The partial character is never written.
- Latency from the input edge to start detection: 3 clocks (2 synchronizer stages plus the edge register).
- Latency from the last stop sample to the FIFO write: 1 clock.
- o_empty falls the clock after the write. o_rd_data and the head flags are valid in that same cycle.
- i_rd pop: the next entry, or o_empty = 1, appears on the following clock.
- o_busy rises when START confirms the start bit and falls at the final stop sample.

## Test plan
- 9600 baud (326 clocks/tick), 8N1, serial 0xA5 -> one entry: 0xA5, par_err = 0, frm_err = 0; o_empty falls about 9.5 bit times (≈49,550 clocks) after the start edge.
- 1200 baud, 7O2, byte 0x35 with correct odd parity, then a second frame with the parity bit flipped -> entry 0x35 with par_err = 0, then 0x35 with par_err = 1.
- 4800 baud, 8E1, 0x3C with the stop bit driven low -> entry 0x3C with frm_err = 1. Line then returns high; the next frame 0x81 is received clean.
- 5-clock low glitch on an idle line at 9600 -> no FIFO write, o_busy stays 0.
- 9 back-to-back frames (0x00–0x08) at 9600 with no reads -> o_full after the 8th. 9th frame: o_overrun pulses once. The reads that follow return 0x00–0x07 in order.
- Assert i_rst during DATA of frame 0x55, release, send 0x66 -> FIFO contains only 0x66.
